nibble_serial_adder: RTL and testbench

//   Multi-cycle WIDTH-bit adder that reuses a single 4-bit ripple slice over NIBBLES cycles.
//   It sits between an operand producer and a result consumer.

---
 rtl/nibble_serial_adder_pkg.sv | 17 +
 rtl/nibble_serial_adder_if.sv | 25 ++
 rtl/nibble_serial_adder_nibble_adder.sv | 27 ++
 rtl/nibble_serial_adder.sv | 125 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants, FSM state type and sizing helper for the nibble-serial adder.
package serial_add_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Index counter width; a single-nibble adder still needs a 1-bit counter.
  function automatic int unsigned idx_width(input int unsigned nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle between producer/consumer (master) and the adder (slave).
interface nibble_serial_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_co;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_ci, out_ready,
    input  in_ready, out_valid, out_sum, out_co, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_ci, out_ready,
    output in_ready, out_valid, out_sum, out_co, busy
  );
endinterface

// File: rtl/nibble_serial_adder_nibble_adder.sv
// Combinational 4-bit ripple slice built from propagate/generate full adders.
module nibble_adder
  import serial_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W:0]   c;

  assign p    = a ^ b;
  assign g    = a & b;
  assign c[0] = ci;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_ripple
    assign c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign s  = p ^ c[NIBBLE_W-1:0];
  assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that iterates one shared 4-bit slice over NIBBLES cycles,
// with valid/ready on both the operand and result sides.
module nibble_serial_adder
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  nibble_serial_adder_if.slave bus
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = idx_width(NIBBLES);
  localparam int unsigned OFF_W   = IDX_W + $clog2(NIBBLE_W);
  localparam logic [WIDTH-1:0] NIB_MASK = WIDTH'((1 << NIBBLE_W) - 1);

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               co_q, co_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [OFF_W-1:0]    bit_off;
  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
  logic                nib_co;

  // Bit offset of the nibble currently being added; selects slice inputs and sum lane.
  assign bit_off = OFF_W'(idx_q) * OFF_W'(NIBBLE_W);
  assign nib_a   = NIBBLE_W'(a_q >> bit_off);
  assign nib_b   = NIBBLE_W'(b_q >> bit_off);

  nibble_adder u_slice (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry_q),
    .s  (nib_s),
    .co (nib_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    co_d    = co_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          carry_d = bus.in_ci;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum_q & ~(NIB_MASK << bit_off)) | (WIDTH'(nib_s) << bit_off);
        carry_d = nib_co;
        if (idx_q == IDX_W'(NIBBLES - 1)) begin
          co_d    = nib_co;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags are registered copies of the next state.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == RUN) || (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      co_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      co_q        <= co_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_co    = co_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: directed and random operations against an arithmetic model, 16-bit and 4-bit instances.
module tb_nibble_serial_adder;

  localparam int unsigned N16 = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(16)) if16 ();
  nibble_serial_adder_if #(.WIDTH(4))  if4 ();

  nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  nibble_serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  int hs_cyc  = 0;
  bit prev_ov  = 1'b0;
  bit after_hs = 1'b0;
  logic [16:0] exp_q[$];

  function automatic logic [16:0] model16(input logic [15:0] a, input logic [15:0] b, input logic ci);
    return 17'(a) + 17'(b) + 17'(ci);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: bound expired, got no event, expected one", name);
  endtask

  // Scoreboard on the 16-bit instance: model results queued at accept, checked while out_valid.
  always @(negedge clk) begin
    logic [16:0] e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      prev_ov  = 1'b0;
      after_hs = 1'b0;
    end else begin
      if (after_hs) begin
        check("ready_after_handshake", 32'(if16.in_ready), 32'd1);
        after_hs = 1'b0;
      end
      if (if16.out_valid) begin
        check("no_bypass_ready", 32'(if16.in_ready), 32'd0);
        check("busy_in_done", 32'(if16.busy), 32'd1);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL spurious_valid: got out_valid=1, expected 0 (no op pending)");
        end else begin
          if (!prev_ov) check("latency_model", 32'(cyc - acc_cyc), 32'(N16 + 1));
          e = exp_q[0];
          check("sum_model", 32'(if16.out_sum), 32'(e[15:0]));
          check("co_model", 32'(if16.out_co), 32'(e[16]));
          if (if16.out_ready) begin
            void'(exp_q.pop_front());
            hs_cyc   = cyc;
            after_hs = 1'b1;
          end
        end
      end
      if (if16.in_valid && if16.in_ready) begin
        exp_q.push_back(model16(if16.in_a, if16.in_b, if16.in_ci));
        acc_cyc = cyc;
      end
      prev_ov = if16.out_valid;
    end
  end

  task automatic accept16(output bit ok);
    ok = 1'b0;
    if16.in_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (if16.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if16.in_valid = 1'b0;
    if16.in_a  = 16'($urandom);
    if16.in_b  = 16'($urandom);
    if16.in_ci = 1'($urandom);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic [15:0] es, input logic eco, input int stall);
    bit ok;
    int k;
    if16.in_a  = a;
    if16.in_b  = b;
    if16.in_ci = ci;
    accept16(ok);
    if (!ok) begin
      fail_now("accept_timeout");
      return;
    end
    k = 0;
    for (int t = 1; t <= 20; t++) begin
      @(posedge clk);
      #1;
      if (if16.out_valid) begin
        k = t;
        break;
      end
    end
    if (k == 0) begin
      fail_now("result_timeout");
      return;
    end
    check("latency", 32'(k), 32'(N16));
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", 32'(if16.out_valid), 32'd1);
      check("stall_ready", 32'(if16.in_ready), 32'd0);
      check("stall_sum", 32'(if16.out_sum), 32'(es));
      check("stall_co", 32'(if16.out_co), 32'(eco));
      @(posedge clk);
      #1;
    end
    check("sum", 32'(if16.out_sum), 32'(es));
    check("co", 32'(if16.out_co), 32'(eco));
    if16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if16.out_ready = 1'b0;
    check("idle_valid", 32'(if16.out_valid), 32'd0);
    check("idle_ready", 32'(if16.in_ready), 32'd1);
    check("idle_busy", 32'(if16.busy), 32'd0);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                     input logic [3:0] es, input logic eco);
    bit ok;
    if4.in_a     = a;
    if4.in_b     = b;
    if4.in_ci    = ci;
    if4.in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (if4.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if4.in_valid = 1'b0;
    if4.in_a     = 4'($urandom);
    if4.in_b     = 4'($urandom);
    if (!ok) begin
      fail_now("w4_accept_timeout");
      return;
    end
    check("w4_valid_early", 32'(if4.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("w4_valid", 32'(if4.out_valid), 32'd1);
    check("w4_sum", 32'(if4.out_sum), 32'(es));
    check("w4_co", 32'(if4.out_co), 32'(eco));
    check("w4_ready_done", 32'(if4.in_ready), 32'd0);
    if4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if4.out_ready = 1'b0;
    check("w4_idle_valid", 32'(if4.out_valid), 32'd0);
    check("w4_idle_ready", 32'(if4.in_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] m;
    logic [3:0]  qa, qb;
    logic [4:0]  m4;
    bit          ok;

    rst_n = 1'b0;
    if16.in_valid = 1'b0; if16.in_a = '0; if16.in_b = '0; if16.in_ci = 1'b0; if16.out_ready = 1'b0;
    if4.in_valid  = 1'b0; if4.in_a  = '0; if4.in_b  = '0; if4.in_ci  = 1'b0; if4.out_ready  = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(if16.out_valid), 32'd0);
    check("rst_busy", 32'(if16.busy), 32'd0);
    check("rst_ready", 32'(if16.in_ready), 32'd0);
    check("rst_sum", 32'(if16.out_sum), 32'd0);
    check("rst_ready_w4", 32'(if4.in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_ready", 32'(if16.in_ready), 32'd1);

    // Directed arithmetic, including full-width carry ripple.
    do_op(16'h0002, 16'h0001, 1'b0, 16'h0003, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0);
    do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 2);

    // Backpressure for six cycles in DONE.
    do_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 6);

    // Reset while idx==2, then a fresh op.
    if16.in_a = 16'h1234; if16.in_b = 16'h1111; if16.in_ci = 1'b0;
    accept16(ok);
    if (!ok) fail_now("midop_accept_timeout");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", 32'(if16.out_valid), 32'd0);
    check("midrst_busy", 32'(if16.busy), 32'd0);
    check("midrst_ready", 32'(if16.in_ready), 32'd0);
    check("midrst_sum", 32'(if16.out_sum), 32'd0);
    check("midrst_co", 32'(if16.out_co), 32'd0);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("midrst_no_valid", 32'(if16.out_valid), 32'd0);
    end
    do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 0);

    // Back-to-back: in_valid held, out_ready held.
    if16.out_ready = 1'b1;
    if16.in_a = 16'hABCD; if16.in_b = 16'h1357; if16.in_ci = 1'b1;
    if16.in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); #1;
      if (if16.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("b2b_first_accept");
    @(posedge clk); #1;
    if16.in_a = 16'h7FFF; if16.in_b = 16'h0001; if16.in_ci = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); #1;
      if (if16.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("b2b_second_accept");
    else check("b2b_gap", 32'(cyc - hs_cyc), 32'd1);
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); #1;
      if (if16.out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("b2b_second_result");
    else begin
      check("b2b_sum", 32'(if16.out_sum), 32'h8000);
      check("b2b_co", 32'(if16.out_co), 32'd0);
    end
    @(posedge clk); #1;
    if16.out_ready = 1'b0;

    // Random operations with random stalls and idle gaps.
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if (i % 5 == 0) rb = 16'hFFFF - ra;
      m = model16(ra, rb, rc);
      do_op(ra, rb, rc, m[15:0], m[16], int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Single-nibble instance: one-cycle latency.
    op4(4'hF, 4'h1, 1'b0, 4'h0, 1'b1);
    op4(4'h7, 4'h8, 1'b1, 4'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      qa = 4'($urandom);
      qb = 4'($urandom);
      rc = 1'($urandom);
      m4 = 5'(qa) + 5'(qb) + 5'(rc);
      op4(qa, qb, rc, m4[3:0], m4[4]);
    end

    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL leftover_ops: got %0d pending results, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
